// File: rtl/nibble_serial_adder_if.sv
// Handshake and data bundle between a SAP datapath controller and nibble_serial_adder.
// Latency: none; wires only.
// Backpressure: none; a start raised while busy is simply not accepted.
// Signals: start/sub/a/b (controller -> adder), busy/done/sum/cout/zero/ovf (adder -> controller).
interface nibble_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, zero, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, zero, ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Time-multiplexed add/subtract: one SLICE-bit '283-style slice reused over N = WIDTH/SLICE cycles.
// Latency: N+1 rising edges from the start sample to the done pulse; one result per N+1 cycles.
// Backpressure: start is only sampled in IDLE; a start while busy is dropped, never queued.
//
// Ports: clk, rst (synchronous, active-high), bus (nibble_serial_adder_if.slave):
//   start/sub/a/b in; busy, done (1-cycle pulse), sum, cout, zero, ovf out (all registered).
// Optional macro NIBBLE_SERIAL_ADDER_SAT_EN: saturate sum to signed max/min on overflow.
// WIDTH must be a non-zero multiple of SLICE.
module nibble_serial_adder #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;     // already inverted for subtraction
    logic [WIDTH-1:0] acc;      // partial result, never exposed on sum
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             zero_q;
    logic             ovf_q;

    // Slice datapath
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_g;
    logic [SLICE-1:0] sl_p;
    logic [SLICE-1:0] sl_sum;
    logic             cc;
    logic [WIDTH-1:0] word;     // accumulator with the current slice merged in
    logic [WIDTH-1:0] result;   // word after optional saturation
    logic             word_ovf;

    always_comb begin
        sl_a = op_a[idx*SLICE +: SLICE];
        sl_b = op_b[idx*SLICE +: SLICE];
        sl_g = sl_a & sl_b;
        sl_p = sl_a ^ sl_b;
        // Generate/propagate carry chain, the same formulation as the '283.
        cc     = carry;
        sl_sum = '0;
        for (int i = 0; i < SLICE; i++) begin
            sl_sum[i] = sl_p[i] ^ cc;
            cc        = sl_g[i] | (sl_p[i] & cc);
        end

        word = acc;
        word[idx*SLICE +: SLICE] = sl_sum;

        // op_b is the effective addend (~b for sub), so this one rule covers both operations.
        word_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (word[WIDTH-1] != op_a[WIDTH-1]);

        result = word;
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
        if (word_ovf) begin
            result = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_b   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub;   // +1 completes the two's complement of b
                        acc    <= '0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= word;
                    carry <= cc;
                    idx   <= idx + IDXW'(1);
                    if (idx == LAST_IDX) begin
                        sum_q  <= result;
                        cout_q <= cc;
                        zero_q <= (result == '0);
                        ovf_q  <= word_ovf;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        idx    <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
endmodule
